pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central sequencing controller for the 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
- Owns the fetch PC and the per-stage valid bits.
- Generates the load enables for the IF/ID and ID/EX stage registers.
- Detects load-use hazards, holds the pipe for multi-cycle EX operations, flushes younger stages on a taken branch resolved in EX, and keeps stall/flush performance counters.

Parameters:
- RESET_PC, 32'h1bfffffc, PC value held during reset; the first valid fetch is RESET_PC+4 = 32'h1c000000.
- MC_CYCLES, 8, total EX-stage residency in cycles of a multi-cycle op (legal range 2..16).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rj  in  5  ID source register 1 index.
- id_rk  in  5  ID source register 2 index.
- id_use_rj  in  1  ID instruction reads rj.
- id_use_rk  in  1  ID instruction reads rk.
- ex_dest  in  5  EX destination register.
- ex_wen  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- ex_is_mc  in  1  EX instruction is multi-cycle (mul/div).
- ex_br_taken  in  1  EX branch resolved taken.
- ex_br_target  in  32  taken-branch target.
- if_pc  out  32  fetch PC register.
- if_valid  out  1  IF stage holds a valid fetch.
- id_en  out  1  load enable for the IF/ID register.
- id_valid  out  1  ID stage valid.
- ex_en  out  1  load enable for the ID/EX register.
- ex_valid  out  1  EX stage valid.
- mem_valid  out  1  MEM stage valid.
- wb_valid  out  1  WB stage valid.
- stall_cnt  out  32  cycles with id_stall asserted.
- flush_cnt  out  32  taken-branch flushes.

Behaviour:
- Reset (rst=0, asynchronous):
  - if_pc=RESET_PC.
  - if_valid, id_valid, ex_valid, mem_valid, wb_valid = 0.
  - mc_cnt=0, stall_cnt=0, flush_cnt=0.
  - Reset asserted mid-operation drops all in-flight state immediately; there is no drain.
- Combinational terms:
  - ex_busy = ex_valid & ex_is_mc & (mc_cnt != MC_CYCLES-1).
  - load_use = id_valid & ex_valid & ex_is_load & ex_wen & (ex_dest != 0) & ((id_use_rj & id_rj==ex_dest) | (id_use_rk & id_rk==ex_dest)). Register 0 never causes a hazard.
  - br = ex_valid & ex_br_taken & !ex_busy.
  - id_stall = load_use | ex_busy.
  - id_en = br | !id_stall.
  - ex_en = !ex_busy.
- Forwarding from EX/MEM/WB is handled elsewhere; only load-in-EX causes a stall.
- PC update priority: br → if_pc<=ex_br_target; else !id_stall → if_pc<=if_pc+4 (mod 2^32); else hold.
- Valid-bit updates:
  - if_valid <= 1 after the first clock following reset release, and stays 1.
  - if_valid is not cleared by br; the new target fetch is valid.
  - id_valid <= br ? 0 : id_stall ? id_valid : if_valid.
  - ex_valid <= ex_busy ? 1 : (id_valid & !load_use & !br). A load-use stall inserts an EX bubble.
  - mem_valid <= ex_valid & !ex_busy.
  - wb_valid <= mem_valid.
- Multi-cycle counter:
  - mc_cnt increments while ex_busy.
  - mc_cnt clears to 0 when EX advances (ex_en=1).
  - A multi-cycle op therefore occupies EX exactly MC_CYCLES cycles.
- Simultaneous events:
  - br together with load_use: the flush wins. ID is killed, no stall, and stall_cnt does not increment.
  - br cannot coincide with ex_busy, since br is gated by !ex_busy.
  - Back-to-back multi-cycle ops each take MC_CYCLES cycles; mc_cnt restarts at 0.
- Counters:
  - stall_cnt += 1 on every cycle with id_stall & !br.
  - flush_cnt += 1 on every cycle with br.
  - Both counters are 32-bit and wrap at 2^32.

Test Plan:
- Reset release with no hazards → if_pc goes 1bfffffc, 1c000000, 1c000004, ...; if_valid rises 1 cycle after release; id_valid, ex_valid, mem_valid, wb_valid rise on successive cycles.
- Load in EX with ex_dest=5 and ID reads rj=5 → exactly 1 stall cycle (id_en=0, if_pc held); ex_valid=0 next cycle; stall_cnt=1. Repeat with dest=0 → no stall.
- Multi-cycle op with MC_CYCLES=8 → ex_en=0 for 7 cycles; mem_valid=0 for 7 cycles, then 1; stall_cnt increases by 7.
- Taken branch in EX with target 1c000100 → next if_pc=1c000100; id_valid=0 and ex_valid=0 next cycle; flush_cnt=1.
- Taken branch and load_use in the same cycle → flush only; stall_cnt unchanged; flush_cnt incremented.
- Assert rst during a multi-cycle op → all valid bits and mc_cnt clear immediately; if_pc=1bfffffc.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Sequencing controller for a 5-stage in-order pipeline: fetch PC, stage valids,
// load-use / multi-cycle stalls, taken-branch flush and stall/flush counters.
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h1bfffffc,
    parameter int unsigned MC_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rj,
    input  logic [4:0]  id_rk,
    input  logic        id_use_rj,
    input  logic        id_use_rk,
    input  logic [4:0]  ex_dest,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic        ex_is_mc,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        id_en,
    output logic        id_valid,
    output logic        ex_en,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // Index of the final EX cycle of a multi-cycle op; 4 bits cover MC_CYCLES up to 16.
    localparam logic [3:0] MC_LAST = 4'(MC_CYCLES - 1);

    logic [3:0] mc_cnt;
    logic       ex_busy;
    logic       rj_hit;
    logic       rk_hit;
    logic       load_use;
    logic       br;
    logic       id_stall;

    assign ex_busy  = ex_valid & ex_is_mc & (mc_cnt != MC_LAST);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign rj_hit   = id_use_rj & (id_rj == ex_dest);
    assign rk_hit   = id_use_rk & (id_rk == ex_dest);
    assign load_use = id_valid & ex_valid & ex_is_load & ex_wen & (ex_dest != 5'd0)
                      & (rj_hit | rk_hit);

    assign br       = ex_valid & ex_br_taken & ~ex_busy;
    assign id_stall = load_use | ex_busy;
    assign id_en    = br | ~id_stall;
    assign ex_en    = ~ex_busy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flop behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc     <= RESET_PC;
            if_valid  <= 1'b0;
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            mc_cnt    <= 4'd0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if_valid <= 1'b1;

            if (br)
                if_pc <= ex_br_target;
            else if (!id_stall)
                if_pc <= if_pc + 32'd4;

            if (br)
                id_valid <= 1'b0;
            else if (!id_stall)
                id_valid <= if_valid;

            // A held multi-cycle op stays valid; a load-use stall leaves a bubble behind.
            ex_valid  <= ex_busy | (id_valid & ~load_use & ~br);
            mem_valid <= ex_valid & ~ex_busy;
            wb_valid  <= mem_valid;

            mc_cnt <= ex_busy ? mc_cnt + 4'd1 : 4'd0;

            if (id_stall && !br)
                stall_cnt <= stall_cnt + 32'd1;
            if (br)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: pipeline fill, load-use, multi-cycle
// hold, taken-branch flush, branch-over-hazard priority and mid-operation reset.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rj, id_rk, ex_dest;
    logic        id_use_rj, id_use_rk, ex_wen, ex_is_load, ex_is_mc, ex_br_taken;
    logic [31:0] ex_br_target;
    logic [31:0] if_pc, stall_cnt, flush_cnt;
    logic        if_valid, id_en, id_valid, ex_en, ex_valid, mem_valid, wb_valid;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.RESET_PC(32'h1bfffffc), .MC_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .id_rj(id_rj), .id_rk(id_rk), .id_use_rj(id_use_rj), .id_use_rk(id_use_rk),
        .ex_dest(ex_dest), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .if_pc(if_pc), .if_valid(if_valid), .id_en(id_en), .id_valid(id_valid),
        .ex_en(ex_en), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rj = 5'd0; id_rk = 5'd0; id_use_rj = 1'b0; id_use_rk = 1'b0;
        ex_dest = 5'd0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_is_mc = 1'b0;
        ex_br_taken = 1'b0; ex_br_target = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        total++; if (if_pc !== 32'h1bfffffc) begin bad++; $display("FAIL rst_pc: got=%h exp=%h", if_pc, 32'h1bfffffc); end
        total++; if ({if_valid, id_valid, ex_valid, mem_valid, wb_valid} !== 5'b00000) begin bad++; $display("FAIL rst_valids: got=%b exp=00000", {if_valid, id_valid, ex_valid, mem_valid, wb_valid}); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnts: got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        total++; if (id_en !== 1'b1 || ex_en !== 1'b1) begin bad++; $display("FAIL rst_en: got=%b%b exp=11", id_en, ex_en); end
        rst = 1'b1;
    endtask

    task automatic test_fill();
        step();
        total++; if (if_pc !== 32'h1c000000) begin bad++; $display("FAIL fill_pc1: got=%h exp=%h", if_pc, 32'h1c000000); end
        total++; if (if_valid !== 1'b1 || id_valid !== 1'b0) begin bad++; $display("FAIL fill_v1: got=%b%b exp=10", if_valid, id_valid); end
        step();
        total++; if (if_pc !== 32'h1c000004) begin bad++; $display("FAIL fill_pc2: got=%h exp=%h", if_pc, 32'h1c000004); end
        total++; if (id_valid !== 1'b1 || ex_valid !== 1'b0) begin bad++; $display("FAIL fill_v2: got=%b%b exp=10", id_valid, ex_valid); end
        step();
        total++; if (ex_valid !== 1'b1 || mem_valid !== 1'b0) begin bad++; $display("FAIL fill_v3: got=%b%b exp=10", ex_valid, mem_valid); end
        step();
        total++; if (mem_valid !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL fill_v4: got=%b%b exp=10", mem_valid, wb_valid); end
        step();
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL fill_v5: got=%b exp=1", wb_valid); end
        total++; if (if_pc !== 32'h1c000010) begin bad++; $display("FAIL fill_pc5: got=%h exp=%h", if_pc, 32'h1c000010); end
    endtask

    task automatic test_load_use();
        // Load to r5 in EX, ID reads r5 through rj.
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_dest = 5'd5; id_use_rj = 1'b1; id_rj = 5'd5;
        #1;
        total++; if (id_en !== 1'b0 || ex_en !== 1'b1) begin bad++; $display("FAIL lu_en: got=%b%b exp=01", id_en, ex_en); end
        step();
        total++; if (if_pc !== 32'h1c000010) begin bad++; $display("FAIL lu_pc_hold: got=%h exp=%h", if_pc, 32'h1c000010); end
        total++; if (ex_valid !== 1'b0 || id_valid !== 1'b1) begin bad++; $display("FAIL lu_bubble: got=%b%b exp=01", ex_valid, id_valid); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt: got=%0d exp=1", stall_cnt); end
        clear_inputs();
        #1;
        total++; if (id_en !== 1'b1) begin bad++; $display("FAIL lu_release: got=%b exp=1", id_en); end
        step();
        total++; if (if_pc !== 32'h1c000014 || ex_valid !== 1'b1) begin bad++; $display("FAIL lu_resume: got=%h/%b exp=1c000014/1", if_pc, ex_valid); end
        // Matching rj index but rj not used, rk used with a different index.
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_dest = 5'd5; id_rj = 5'd5; id_use_rk = 1'b1; id_rk = 5'd9;
        #1;
        total++; if (id_en !== 1'b1) begin bad++; $display("FAIL lu_unused_rj: got=%b exp=1", id_en); end
        // Register 0 never hazards.
        ex_dest = 5'd0; id_rj = 5'd0; id_use_rj = 1'b1; id_use_rk = 1'b0;
        #1;
        total++; if (id_en !== 1'b1) begin bad++; $display("FAIL lu_r0: got=%b exp=1", id_en); end
        step();
        total++; if (if_pc !== 32'h1c000018 || stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_r0_adv: got=%h/%0d exp=1c000018/1", if_pc, stall_cnt); end
        // Non-load producer does not stall; the same operands as a load do.
        clear_inputs();
        ex_wen = 1'b1; ex_dest = 5'd7; id_use_rk = 1'b1; id_rk = 5'd7;
        #1;
        total++; if (id_en !== 1'b1) begin bad++; $display("FAIL lu_nonload: got=%b exp=1", id_en); end
        ex_is_load = 1'b1;
        #1;
        total++; if (id_en !== 1'b0) begin bad++; $display("FAIL lu_rk: got=%b exp=0", id_en); end
        step();
        total++; if (if_pc !== 32'h1c000018 || stall_cnt !== 32'd2 || ex_valid !== 1'b0) begin bad++; $display("FAIL lu_rk_stall: got=%h/%0d/%b exp=1c000018/2/0", if_pc, stall_cnt, ex_valid); end
        clear_inputs();
        step();
        total++; if (if_pc !== 32'h1c00001c || ex_valid !== 1'b1) begin bad++; $display("FAIL lu_rk_resume: got=%h/%b exp=1c00001c/1", if_pc, ex_valid); end
    endtask

    // Two back-to-back multi-cycle ops of 8 EX cycles each: 7 held cycles apiece.
    task automatic test_multicycle();
        logic [31:0] hold_pc;
        ex_is_mc = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            hold_pc = 32'h1c00001c + 32'(4 * rep);
            for (int k = 0; k < 7; k++) begin
                #1;
                total++; if (ex_en !== 1'b0 || id_en !== 1'b0) begin bad++; $display("FAIL mc_busy r%0d c%0d: got=%b%b exp=00", rep, k, ex_en, id_en); end
                step();
                total++; if (mem_valid !== 1'b0 || if_pc !== hold_pc || ex_valid !== 1'b1) begin bad++; $display("FAIL mc_hold r%0d c%0d: got=%b/%h/%b exp=0/%h/1", rep, k, mem_valid, if_pc, ex_valid, hold_pc); end
            end
            total++; if (ex_en !== 1'b1) begin bad++; $display("FAIL mc_last r%0d: got=%b exp=1", rep, ex_en); end
            if (rep == 1) ex_is_mc = 1'b0;
            step();
            total++; if (mem_valid !== 1'b1 || if_pc !== hold_pc + 32'd4) begin bad++; $display("FAIL mc_done r%0d: got=%b/%h exp=1/%h", rep, mem_valid, if_pc, hold_pc + 32'd4); end
        end
        total++; if (stall_cnt !== 32'd16) begin bad++; $display("FAIL mc_stall_cnt: got=%0d exp=16", stall_cnt); end
    endtask

    task automatic test_branch();
        ex_br_taken = 1'b1; ex_br_target = 32'h1c000100;
        #1;
        total++; if (id_en !== 1'b1 || ex_en !== 1'b1) begin bad++; $display("FAIL br_en: got=%b%b exp=11", id_en, ex_en); end
        step();
        total++; if (if_pc !== 32'h1c000100) begin bad++; $display("FAIL br_pc: got=%h exp=%h", if_pc, 32'h1c000100); end
        total++; if ({if_valid, id_valid, ex_valid} !== 3'b100) begin bad++; $display("FAIL br_flush: got=%b exp=100", {if_valid, id_valid, ex_valid}); end
        total++; if (flush_cnt !== 32'd1) begin bad++; $display("FAIL br_flush_cnt: got=%0d exp=1", flush_cnt); end
        // EX now holds a bubble, so a taken indication must be ignored.
        ex_br_target = 32'h20000000;
        step();
        total++; if (if_pc !== 32'h1c000104 || flush_cnt !== 32'd1) begin bad++; $display("FAIL br_bubble: got=%h/%0d exp=1c000104/1", if_pc, flush_cnt); end
        clear_inputs();
        step();
        total++; if (if_pc !== 32'h1c000108 || ex_valid !== 1'b1) begin bad++; $display("FAIL br_refill: got=%h/%b exp=1c000108/1", if_pc, ex_valid); end
    endtask

    task automatic test_branch_load_use();
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_dest = 5'd3; id_use_rk = 1'b1; id_rk = 5'd3;
        ex_br_taken = 1'b1; ex_br_target = 32'h1c000200;
        #1;
        total++; if (id_en !== 1'b1) begin bad++; $display("FAIL brlu_en: got=%b exp=1", id_en); end
        step();
        total++; if (if_pc !== 32'h1c000200) begin bad++; $display("FAIL brlu_pc: got=%h exp=%h", if_pc, 32'h1c000200); end
        total++; if (stall_cnt !== 32'd16 || flush_cnt !== 32'd2) begin bad++; $display("FAIL brlu_cnts: got=%0d/%0d exp=16/2", stall_cnt, flush_cnt); end
        total++; if (id_valid !== 1'b0 || ex_valid !== 1'b0) begin bad++; $display("FAIL brlu_kill: got=%b%b exp=00", id_valid, ex_valid); end
        clear_inputs();
        step();
        step();
        total++; if (if_pc !== 32'h1c000208 || ex_valid !== 1'b1) begin bad++; $display("FAIL brlu_refill: got=%h/%b exp=1c000208/1", if_pc, ex_valid); end
    endtask

    task automatic test_reset_mid_mc();
        ex_is_mc = 1'b1;
        step(); step(); step();
        total++; if (ex_en !== 1'b0 || if_pc !== 32'h1c000208) begin bad++; $display("FAIL rmc_busy: got=%b/%h exp=0/1c000208", ex_en, if_pc); end
        rst = 1'b0;
        #1;
        total++; if (if_pc !== 32'h1bfffffc) begin bad++; $display("FAIL rmc_pc: got=%h exp=%h", if_pc, 32'h1bfffffc); end
        total++; if ({if_valid, id_valid, ex_valid, mem_valid, wb_valid} !== 5'b00000) begin bad++; $display("FAIL rmc_valids: got=%b exp=00000", {if_valid, id_valid, ex_valid, mem_valid, wb_valid}); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || ex_en !== 1'b1) begin bad++; $display("FAIL rmc_cnts: got=%0d/%0d/%b exp=0/0/1", stall_cnt, flush_cnt, ex_en); end
        clear_inputs();
        rst = 1'b1;
        step();
        total++; if (if_pc !== 32'h1c000000 || if_valid !== 1'b1) begin bad++; $display("FAIL rmc_restart: got=%h/%b exp=1c000000/1", if_pc, if_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_load_use();
        test_multicycle();
        test_branch();
        test_branch_load_use();
        test_reset_mid_mc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
